// File: rtl/rr_arbiter.sv
// Registered N-way arbiter: fixed-priority, round-robin, forced, all-off/all-on and hold modes.
// Optional starvation override enabled by defining ARB_STARVE_GUARD_EN.
module rr_arbiter #(
    parameter int N          = 4,
    parameter int STARVE_MAX = 7,
    localparam int IW        = ($clog2(N) > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic [2:0]    opcode,
    input  logic [IW-1:0] force_idx,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_valid,
    output logic          op_error,
    output logic          starved
);

    typedef enum logic [2:0] {
        OP_FIX   = 3'b000,
        OP_RR    = 3'b001,
        OP_FORCE = 3'b010,
        OP_OFF   = 3'b011,
        OP_ON    = 3'b100,
        OP_HOLD  = 3'b101
    } op_e;

    function automatic logic [N-1:0] onehot(input logic [IW-1:0] idx);
        return {{(N-1){1'b0}}, 1'b1} << idx;
    endfunction

    function automatic logic [IW-1:0] inc_mod(input logic [IW-1:0] idx);
        return (idx == IW'(N - 1)) ? '0 : idx + IW'(1);
    endfunction

    logic [IW-1:0] rr_ptr, rr_ptr_n;
    logic [N-1:0]  gnt_n;
    logic [IW-1:0] gnt_idx_n;
    logic          op_error_n, starved_n;
    logic          fix_found, rr_found;
    logic [IW-1:0] fix_win, rr_win;
    logic          starve_hit;
    logic [IW-1:0] starve_win;
    int            rr_pos;

`ifdef ARB_STARVE_GUARD_EN
    logic [7:0] wait_cnt [N];

    // A requester stops waiting on the edge its grant is issued, so an override
    // winner is not picked a second time on the following cycle.
    // NOTE: the wait counters are a handful of flops, not a RAM, so they take the reset like any other state.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) wait_cnt[i] <= 8'd0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (req[i] && !gnt_n[i]) begin
                    if (wait_cnt[i] != 8'(STARVE_MAX)) wait_cnt[i] <= wait_cnt[i] + 8'd1;
                end else begin
                    wait_cnt[i] <= 8'd0;
                end
            end
        end
    end

    always_comb begin
        starve_hit = 1'b0;
        starve_win = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i] && wait_cnt[i] == 8'(STARVE_MAX)) begin
                starve_hit = 1'b1;
                starve_win = IW'(i);
            end
        end
    end
`else
    assign starve_hit = 1'b0;
    assign starve_win = '0;
`endif

    // NOTE: every combinational output gets a default before any branch, so no path can infer a latch.
    always_comb begin
        // NOTE: blocking assignments here, since later statements must see the updated values.
        fix_found = 1'b0;
        fix_win   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                fix_found = 1'b1;
                fix_win   = IW'(i);
            end
        end

        rr_found = 1'b0;
        rr_win   = '0;
        rr_pos   = 0;
        for (int k = 0; k < N; k++) begin
            rr_pos = int'(rr_ptr) + k;
            if (rr_pos >= N) rr_pos = rr_pos - N;
            if (!rr_found && req[rr_pos]) begin
                rr_found = 1'b1;
                rr_win   = IW'(rr_pos);
            end
        end

        gnt_n      = gnt;
        starved_n  = starved;
        op_error_n = 1'b0;
        rr_ptr_n   = rr_ptr;

        case (opcode)
            OP_FIX: begin
                gnt_n     = '0;
                starved_n = starve_hit;
                if (starve_hit)     gnt_n = onehot(starve_win);
                else if (fix_found) gnt_n = onehot(fix_win);
            end
            OP_RR: begin
                gnt_n     = '0;
                starved_n = starve_hit;
                if (starve_hit) begin
                    gnt_n    = onehot(starve_win);
                    rr_ptr_n = inc_mod(starve_win);
                end else if (rr_found) begin
                    gnt_n    = onehot(rr_win);
                    rr_ptr_n = inc_mod(rr_win);
                end
            end
            OP_FORCE: begin
                starved_n = 1'b0;
                if (int'(force_idx) < N) begin
                    gnt_n = onehot(force_idx);
                end else begin
                    gnt_n      = '0;
                    op_error_n = 1'b1;
                end
            end
            OP_OFF: begin
                gnt_n     = '0;
                starved_n = 1'b0;
            end
            OP_ON: begin
                gnt_n     = '1;
                starved_n = 1'b0;
            end
            OP_HOLD: ;
            default: begin
                gnt_n      = '0;
                starved_n  = 1'b0;
                op_error_n = 1'b1;
            end
        endcase

        gnt_idx_n = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (gnt_n[i]) gnt_idx_n = IW'(i);
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            op_error  <= 1'b0;
            starved   <= 1'b0;
            rr_ptr    <= '0;
        end else begin
            gnt       <= gnt_n;
            gnt_idx   <= gnt_idx_n;
            gnt_valid <= |gnt_n;
            op_error  <= op_error_n;
            starved   <= starved_n;
            rr_ptr    <= rr_ptr_n;
        end
    end

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter: a vector table on an N=4 instance, plus sequences for
// starvation and a non-power-of-two N=5 instance.
module tb_rr_arbiter;

    localparam logic [2:0] FIX = 3'b000, RR = 3'b001, FRC = 3'b010, OFF = 3'b011,
                           ON = 3'b100, HLD = 3'b101;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [2:0] opcode;
    logic [1:0] force_idx;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid, op_error, starved;

    logic [4:0] req5;
    logic [2:0] opcode5;
    logic [2:0] force_idx5;
    logic [4:0] gnt5;
    logic [2:0] gnt_idx5;
    logic       gnt_valid5, op_error5, starved5;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rr_arbiter #(.N(4), .STARVE_MAX(7)) dut (
        .clk(clk), .rst(rst), .req(req), .opcode(opcode), .force_idx(force_idx),
        .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .op_error(op_error),
        .starved(starved)
    );

    rr_arbiter #(.N(5), .STARVE_MAX(7)) dut5 (
        .clk(clk), .rst(rst), .req(req5), .opcode(opcode5), .force_idx(force_idx5),
        .gnt(gnt5), .gnt_idx(gnt_idx5), .gnt_valid(gnt_valid5), .op_error(op_error5),
        .starved(starved5)
    );

    typedef struct {
        logic       rst;
        logic [2:0] op;
        logic [3:0] req;
        logic [1:0] fidx;
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       valid;
        logic       err;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [2:0] op, input logic [3:0] rq,
                       input logic [1:0] fi, input logic [3:0] g, input logic [1:0] ix,
                       input logic v, input logic e);
        vec_t t;
        t.rst = r; t.op = op; t.req = rq; t.fidx = fi;
        t.gnt = g; t.idx = ix; t.valid = v; t.err = e;
        tbl.push_back(t);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req = '0; opcode = FIX; force_idx = '0;
        req5 = '0; opcode5 = OFF; force_idx5 = '0;
        step();
        step();

        add(1, FIX, 4'b0000, 0, 4'b0000, 0, 0, 0);
        add(0, FIX, 4'b1010, 0, 4'b0010, 1, 1, 0);
        add(0, FIX, 4'b0000, 0, 4'b0000, 0, 0, 0);
        add(0, FIX, 4'b1100, 0, 4'b0100, 2, 1, 0);
        add(0, RR,  4'b1111, 0, 4'b0001, 0, 1, 0);
        add(0, RR,  4'b1111, 0, 4'b0010, 1, 1, 0);
        add(0, RR,  4'b1111, 0, 4'b0100, 2, 1, 0);
        add(0, RR,  4'b1111, 0, 4'b1000, 3, 1, 0);
        add(0, RR,  4'b1111, 0, 4'b0001, 0, 1, 0);
        add(0, RR,  4'b0000, 0, 4'b0000, 0, 0, 0);
        add(0, RR,  4'b1001, 0, 4'b1000, 3, 1, 0);
        add(0, RR,  4'b1001, 0, 4'b0001, 0, 1, 0);
        add(0, FIX, 4'b0001, 0, 4'b0001, 0, 1, 0);
        add(0, RR,  4'b0101, 0, 4'b0100, 2, 1, 0);
        add(0, FRC, 4'b0000, 2, 4'b0100, 2, 1, 0);
        add(0, 3'b110, 4'b0000, 0, 4'b0000, 0, 0, 1);
        add(0, FIX, 4'b0000, 0, 4'b0000, 0, 0, 0);
        add(0, 3'b111, 4'b1111, 0, 4'b0000, 0, 0, 1);
        add(0, 3'b110, 4'b0000, 0, 4'b0000, 0, 0, 1);
        add(0, HLD, 4'b0000, 0, 4'b0000, 0, 0, 0);
        add(0, ON,  4'b0000, 0, 4'b1111, 0, 1, 0);
        add(0, HLD, 4'b0000, 0, 4'b1111, 0, 1, 0);
        add(0, HLD, 4'b0101, 0, 4'b1111, 0, 1, 0);
        add(0, HLD, 4'b0000, 0, 4'b1111, 0, 1, 0);
        add(0, OFF, 4'b1111, 0, 4'b0000, 0, 0, 0);
        add(0, RR,  4'b1111, 0, 4'b1000, 3, 1, 0);
        add(0, RR,  4'b1111, 0, 4'b0001, 0, 1, 0);
        add(1, RR,  4'b1111, 0, 4'b0000, 0, 0, 0);
        add(0, RR,  4'b1111, 0, 4'b0001, 0, 1, 0);
        add(0, RR,  4'b1111, 0, 4'b0010, 1, 1, 0);
        add(0, RR,  4'b1111, 0, 4'b0100, 2, 1, 0);
        add(0, RR,  4'b1111, 0, 4'b1000, 3, 1, 0);
        add(1, RR,  4'b1111, 0, 4'b0000, 0, 0, 0);
        add(0, RR,  4'b1111, 0, 4'b0001, 0, 1, 0);
        add(0, FRC, 4'b0001, 3, 4'b1000, 3, 1, 0);
        add(0, RR,  4'b0011, 0, 4'b0010, 1, 1, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; opcode = tbl[i].op; req = tbl[i].req; force_idx = tbl[i].fidx;
            step();
            check($sformatf("vec%0d gnt", i),       32'(gnt),       32'(tbl[i].gnt));
            check($sformatf("vec%0d gnt_idx", i),   32'(gnt_idx),   32'(tbl[i].idx));
            check($sformatf("vec%0d gnt_valid", i), 32'(gnt_valid), 32'(tbl[i].valid));
            check($sformatf("vec%0d op_error", i),  32'(op_error),  32'(tbl[i].err));
            check($sformatf("vec%0d starved", i),   32'(starved),   32'(1'b0));
        end

        // Starvation: agent1 waits behind agent0 under fixed priority.
        rst = 1'b1; opcode = FIX; req = '0;
        step();
        rst = 1'b0; req = 4'b0011;
        for (int c = 1; c <= 9; c++) begin
            step();
            check($sformatf("starve c%0d gnt", c), 32'(gnt),
                  (GUARD && c == 8) ? 32'h2 : 32'h1);
            check($sformatf("starve c%0d starved", c), 32'(starved),
                  (GUARD && c == 8) ? 32'h1 : 32'h0);
        end
        req = '0;

        // N=5: out-of-range force index and round-robin wrap at a non-power-of-two width.
        opcode5 = FRC; force_idx5 = 3'd5;
        step();
        check("n5 force5 gnt", 32'(gnt5), 32'h0);
        check("n5 force5 err", 32'(op_error5), 32'h1);
        force_idx5 = 3'd4;
        step();
        check("n5 force4 gnt", 32'(gnt5), 32'h10);
        check("n5 force4 idx", 32'(gnt_idx5), 32'h4);
        check("n5 force4 err", 32'(op_error5), 32'h0);
        force_idx5 = 3'd7;
        step();
        check("n5 force7 err", 32'(op_error5), 32'h1);
        check("n5 force7 valid", 32'(gnt_valid5), 32'h0);
        opcode5 = RR; req5 = 5'b10001;
        step();
        check("n5 rr0 gnt", 32'(gnt5), 32'h01);
        step();
        check("n5 rr1 gnt", 32'(gnt5), 32'h10);
        check("n5 rr1 idx", 32'(gnt_idx5), 32'h4);
        step();
        check("n5 rr2 gnt", 32'(gnt5), 32'h01);
        check("n5 rr2 err", 32'(op_error5), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 The parameter N SHALL default to 4 and set the number of requesters, legal range 2..16.
REQ-002 The parameter STARVE_MAX SHALL default to 7 and set the starvation wait threshold in cycles, legal range 1..255.
REQ-003 The localparam IW SHALL equal max(1,$clog2(N)) and set the index width.
REQ-004 The port list SHALL be: clk, input, 1, rising-edge clock.
REQ-005 rst, input, 1, reset; synchronous to clk, active-high.
REQ-006 req, input, N, request per agent.
REQ-007 opcode, input, 3, mode: 000 NORMAL_FIX, 001 NORMAL_RR, 010 FORCE, 011 ACCESS_OFF, 100 ACCESS_ON, 101 HOLD, 110/111 RESERVED.
REQ-008 force_idx, input, IW, target agent for FORCE.
REQ-009 gnt, output, N, registered grant vector.
REQ-010 gnt_idx, output, IW, index of lowest set bit of gnt, 0 when gnt is 0.
REQ-011 gnt_valid, output, 1, OR-reduction of gnt.
REQ-012 op_error, output, 1, registered illegal-opcode or illegal-index flag.
REQ-013 starved, output, 1, registered; high when the current gnt was issued by starvation override.

Function
REQ-014 All outputs SHALL be registered; each cycle's decision SHALL appear on gnt one clk after opcode/req are sampled.
REQ-015 NORMAL_FIX: the lowest-index asserted req SHALL be granted one-hot; if req is 0, gnt SHALL be 0.
REQ-016 NORMAL_RR: the search SHALL start at rr_ptr and proceed upward, wrapping N-1 to 0; the first asserted req SHALL be granted one-hot.
REQ-017 rr_ptr SHALL be IW bits, SHALL update to (winner+1) mod N only on a NORMAL_RR grant, and SHALL hold under all other opcodes and when req is 0.
REQ-018 FORCE: gnt SHALL be one-hot at force_idx regardless of req; if force_idx >= N, gnt SHALL be 0 and op_error SHALL be 1.
REQ-019 ACCESS_OFF SHALL drive gnt to 0; ACCESS_ON SHALL drive gnt to all ones.
REQ-020 HOLD SHALL keep gnt, starved and rr_ptr unchanged and drive op_error to 0.
REQ-021 RESERVED (110, 111) SHALL drive gnt to 0 and op_error to 1 for that cycle; rr_ptr SHALL hold.
REQ-022 op_error SHALL be 0 for every legal opcode and index; it SHALL not be sticky.
REQ-023 gnt SHALL be one-hot or zero under every opcode except ACCESS_ON.
REQ-024 A wait counter per agent (8 bits) SHALL increment when req[i]=1 and gnt[i]=0, saturate at STARVE_MAX, and clear when req[i]=0 or gnt[i]=1.
REQ-025 Counters SHALL advance under all opcodes, including HOLD and RESERVED.

Reset
REQ-026 When rst=1 at a clk edge: gnt=0, gnt_idx=0, gnt_valid=0, op_error=0, starved=0, rr_ptr=0, all wait counters=0.
REQ-027 rst SHALL override every opcode; reset mid-grant SHALL clear gnt on the same edge with no residual state.
REQ-028 The first decision after rst deasserts SHALL use rr_ptr=0.

Configuration
REQ-029 With macro ARB_STARVE_GUARD_EN defined: in NORMAL_FIX or NORMAL_RR, if any asserted requester's counter equals STARVE_MAX, the lowest-index such requester SHALL be granted instead of the normal winner, starved SHALL be 1, and rr_ptr SHALL update to (that index+1) mod N in NORMAL_RR.
REQ-030 Without ARB_STARVE_GUARD_EN: no override SHALL occur, starved SHALL be tied to 0, and the wait counters SHALL not be built.

Verification (N=4, STARVE_MAX=7)
REQ-031 Reset, then opcode=NORMAL_FIX, req=1010 -> gnt=0010 next cycle, gnt_idx=1, gnt_valid=1.
REQ-032 opcode=NORMAL_RR, req=1111 held for 5 cycles -> gnt sequence 0001,0010,0100,1000,0001.
REQ-033 opcode=FORCE, force_idx=2, req=0000 -> gnt=0100, op_error=0; opcode=110 -> gnt=0000, op_error=1 for exactly one cycle.
REQ-034 opcode=ACCESS_ON -> gnt=1111, gnt_idx=0; then HOLD for 3 cycles -> gnt stays 1111.
REQ-035 ARB_STARVE_GUARD_EN defined, NORMAL_FIX, req=0011 held -> agent1 granted on the 8th grant cycle with starved=1, agent0 granted again the next cycle.
REQ-036 rst asserted while gnt=1000 in NORMAL_RR -> gnt=0000 next edge; after release with req=1111 -> gnt=0001.
